mpu_loader: RTL and testbench
=============================

MPU_LOADER -- requirements
Module: mpu_loader

Interface
REQ-001 The module SHALL take parameter DIM, default 5, as the maximum matrix dimension.
REQ-002 The module SHALL take parameter WIDTH, default 8, as the element width in bits.
REQ-003 The module SHALL use one clock; reset is asynchronous and active-high.
REQ-004 Port: clock  input  1  rising-edge clock for all state.
REQ-005 Port: reset  input  1  asynchronous active-high reset.
REQ-006 Port: in_data  input  8  byte stream carrying the header, then the A elements, then the B elements.
REQ-007 Port: in_valid  input  1  in_data is valid this cycle.
REQ-008 Port: in_ready  output  1  loader accepts in_data this cycle; a transfer occurs when in_valid and in_ready are both 1.
REQ-009 Port: matrix_a  output  200  flattened 5x5 A; element [i][j] at bits ((i*5+j)*8)+7 : (i*5+j)*8.
REQ-010 Port: matrix_b  output  200  flattened 5x5 B, same layout as matrix_a.
REQ-011 Port: size  output  8  latched matrix dimension, 1..5.
REQ-012 Port: out_valid  output  1  matrix_a, matrix_b and size hold a complete operand set.
REQ-013 Port: out_ready  input  1  downstream multiply stage consumes the operand set.
REQ-014 Port: error  output  1  one-cycle pulse marking a rejected header.
REQ-015 Port: busy  output  1  high in LOAD_A, LOAD_B and HOLD.

Function
REQ-016 The FSM SHALL have the states IDLE, LOAD_A, LOAD_B and HOLD.
REQ-017 in_ready SHALL be 1 in IDLE, LOAD_A and LOAD_B, and 0 in HOLD.
REQ-018 IDLE, on a transfer with in_data in 1..5: latch size, zero all 25 elements of both matrices, set row=col=0, go to LOAD_A, all in the same edge.
REQ-019 IDLE, on a transfer with in_data equal to 0 or greater than 5: pulse error for exactly one cycle, stay in IDLE, leave matrices and size unchanged.
REQ-020 LOAD_A, on each transfer: write in_data to A[row][col]; if col=size-1 then col=0 and row=row+1, else col=col+1 (row-major order).
REQ-021 LOAD_A, on the transfer at row=col=size-1: reset row=col=0 and go to LOAD_B.
REQ-022 LOAD_B SHALL behave as LOAD_A but write B; its final transfer at row=col=size-1 goes to HOLD.
REQ-023 out_valid SHALL be 1 exactly while in HOLD, asserting the cycle after the last B byte is accepted (latency 1).
REQ-024 In HOLD, matrix_a, matrix_b and size SHALL stay stable until out_ready=1.
REQ-025 HOLD with out_ready=1 SHALL go to IDLE; out_valid drops next cycle and operands keep their values until the next valid header.
REQ-026 Elements with row or col at or above size SHALL read 0 after any completed load.
REQ-027 Cycles with in_valid=0 SHALL not advance row/col or change state (stall tolerance).
REQ-028 Size 1 SHALL load exactly one A byte and one B byte; size 5 SHALL load 25 bytes each.
REQ-029 Element storage SHALL be raw 8-bit; no arithmetic is performed on data.
REQ-030 out_ready SHALL be ignored outside HOLD, and in_data SHALL be ignored when no transfer occurs.

Reset
REQ-031 reset=1 SHALL force IDLE immediately and asynchronously: matrices all 0, size=0, row=col=0, out_valid=0, error=0, busy=0, in_ready=1 after reset release.
REQ-032 Reset asserted mid-load SHALL discard partial data; the next header starts a fresh load.

Verification
REQ-033 Header 2, A bytes 1,2,3,4, B bytes 5,6,7,8 -> out_valid=1 one cycle after the byte 8 transfer; A[0][0..1]=1,2; A[1][0..1]=3,4; B[1][1]=8; all other elements 0; size=2.
REQ-034 Header 0, then header 6 -> two single-cycle error pulses, state stays IDLE, busy=0, outputs unchanged.
REQ-035 Size 5 load with in_valid toggling every other cycle -> all 50 bytes land in row-major order; A[4][4] equals the 25th data byte.
REQ-036 In HOLD, keep out_ready=0 for 10 cycles while driving in_valid=1 -> in_ready=0, operands stable; then out_ready=1 -> IDLE next cycle, out_valid=0.
REQ-037 Reset pulsed after the 7th A byte of a size-3 load, then a size-1 load of A=9, B=3 -> A[0][0]=9, B[0][0]=3, all other elements 0.
REQ-038 Size 5 load followed by a size 2 load -> rows and columns 2..4 of both matrices read 0.

Source files
------------

// File: rtl/mpu_loader.sv
// Operand loader for the matrix multiply unit. A header byte gives the dimension, then
// A and B arrive row-major; the set is held until the multiply stage takes it.
module mpu_loader #(
    parameter int DIM   = 5,
    parameter int WIDTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [7:0]               in_data,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DIM*DIM*WIDTH-1:0] matrix_a,
    output logic [DIM*DIM*WIDTH-1:0] matrix_b,
    output logic [7:0]               size,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     error,
    output logic                     busy
);
    localparam int IW = (DIM > 1) ? $clog2(DIM) : 1;

    typedef enum logic [1:0] {IDLE, LOAD_A, LOAD_B, HOLD} state_t;

    state_t           state_q, state_d;
    logic [IW-1:0]    row_q, row_d;
    logic [IW-1:0]    col_q, col_d;
    logic [7:0]       size_q, size_d;
    logic             error_q, error_d;
    logic [WIDTH-1:0] memA_q [DIM][DIM];
    logic [WIDTH-1:0] memB_q [DIM][DIM];

    logic       xfer;
    logic       hdrOk;
    logic [7:0] lastIdx;
    logic       atLastCol;
    logic       lastCell;

    assign xfer      = in_valid && in_ready;
    assign hdrOk     = (in_data != 8'd0) && (in_data <= 8'(DIM));
    assign lastIdx   = size_q - 8'd1;
    assign atLastCol = (8'(col_q) == lastIdx);
    assign lastCell  = atLastCol && (8'(row_q) == lastIdx);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (xfer && hdrOk)    state_d = LOAD_A;
            LOAD_A:  if (xfer && lastCell) state_d = LOAD_B;
            LOAD_B:  if (xfer && lastCell) state_d = HOLD;
            HOLD:    if (out_ready)        state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q != HOLD);
        out_valid = (state_q == HOLD);
        busy      = (state_q != IDLE);
        error     = error_q;
        size      = size_q;
    end

    // Cursor walks row-major inside the size x size window; a bad header only raises error.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        size_d  = size_q;
        error_d = 1'b0;
        if (xfer) begin
            unique case (state_q)
                IDLE: begin
                    if (hdrOk) begin
                        size_d = in_data;
                        row_d  = '0;
                        col_d  = '0;
                    end else begin
                        error_d = 1'b1;
                    end
                end
                LOAD_A, LOAD_B: begin
                    if (lastCell) begin
                        row_d = '0;
                        col_d = '0;
                    end else if (atLastCol) begin
                        row_d = row_q + IW'(1);
                        col_d = '0;
                    end else begin
                        col_d = col_q + IW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            row_q   <= '0;
            col_q   <= '0;
            size_q  <= '0;
            error_q <= 1'b0;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            size_q  <= size_d;
            error_q <= error_d;
        end
    end

    // Clearing both matrices on every accepted header keeps cells outside the new window at 0.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DIM; i++) begin
                for (int j = 0; j < DIM; j++) begin
                    memA_q[i][j] <= '0;
                    memB_q[i][j] <= '0;
                end
            end
        end else if (xfer) begin
            if (state_q == IDLE && hdrOk) begin
                for (int i = 0; i < DIM; i++) begin
                    for (int j = 0; j < DIM; j++) begin
                        memA_q[i][j] <= '0;
                        memB_q[i][j] <= '0;
                    end
                end
            end else if (state_q == LOAD_A) begin
                memA_q[row_q][col_q] <= WIDTH'(in_data);
            end else if (state_q == LOAD_B) begin
                memB_q[row_q][col_q] <= WIDTH'(in_data);
            end
        end
    end

    always_comb begin
        matrix_a = '0;
        matrix_b = '0;
        for (int i = 0; i < DIM; i++) begin
            for (int j = 0; j < DIM; j++) begin
                matrix_a[(i*DIM+j)*WIDTH +: WIDTH] = memA_q[i][j];
                matrix_b[(i*DIM+j)*WIDTH +: WIDTH] = memB_q[i][j];
            end
        end
    end

endmodule

// File: tb/tb_mpu_loader.sv
// Scoreboard bench for mpu_loader: expected operand sets are queued when a load is driven
// and compared when out_valid appears.
module tb_mpu_loader;
    localparam int DIM   = 5;
    localparam int WIDTH = 8;
    localparam int VW    = DIM*DIM*WIDTH;

    logic          clock     = 1'b0;
    logic          reset     = 1'b1;
    logic [7:0]    in_data   = 8'd0;
    logic          in_valid  = 1'b0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic [VW-1:0] matrix_a;
    logic [VW-1:0] matrix_b;
    logic [7:0]    size;
    logic          out_valid;
    logic          error;
    logic          busy;

    int checks = 0;
    int errors = 0;

    logic [VW-1:0] expAQ[$];
    logic [VW-1:0] expBQ[$];
    logic [7:0]    expSizeQ[$];
    logic [VW-1:0] curA    = '0;
    logic [VW-1:0] curB    = '0;
    logic [7:0]    curSize = 8'd0;
    logic [7:0]    dataA[25];
    logic [7:0]    dataB[25];

    mpu_loader #(.DIM(DIM), .WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .matrix_a  (matrix_a),
        .matrix_b  (matrix_b),
        .size      (size),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .error     (error),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [VW-1:0] observed,
                               input logic [VW-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [VW-1:0] packMatrix(input int sz, input bit isB);
        logic [VW-1:0] v;
        v = '0;
        for (int i = 0; i < sz; i++) begin
            for (int j = 0; j < sz; j++) begin
                v[(i*DIM+j)*WIDTH +: WIDTH] = isB ? dataB[i*sz+j] : dataA[i*sz+j];
            end
        end
        return v;
    endfunction

    // One transfer on the next rising edge, then gap idle cycles with junk on in_data.
    task automatic applyStimulus(input logic [7:0] b, input int gap);
        @(negedge clock);
        in_data  = b;
        in_valid = 1'b1;
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        in_data  = 8'($urandom);
        repeat (gap) @(posedge clock);
    endtask

    task automatic doReset();
        @(negedge clock);
        reset = 1'b1;
        #2;
        checkOutput("rstA",     matrix_a,       '0);
        checkOutput("rstB",     matrix_b,       '0);
        checkOutput("rstSize",  VW'(size),      '0);
        checkOutput("rstValid", VW'(out_valid), '0);
        checkOutput("rstErr",   VW'(error),     '0);
        checkOutput("rstBusy",  VW'(busy),      '0);
        @(negedge clock);
        reset = 1'b0;
        curA    = '0;
        curB    = '0;
        curSize = 8'd0;
        #1;
        checkOutput("rstReady", VW'(in_ready), VW'(1));
    endtask

    task automatic runLoad(input int sz, input int gap);
        logic [VW-1:0] eA, eB;
        logic [7:0]    eS;
        expAQ.push_back(packMatrix(sz, 1'b0));
        expBQ.push_back(packMatrix(sz, 1'b1));
        expSizeQ.push_back(8'(sz));
        applyStimulus(8'(sz), gap);
        for (int k = 0; k < sz*sz; k++) applyStimulus(dataA[k], gap);
        for (int k = 0; k < sz*sz - 1; k++) applyStimulus(dataB[k], gap);
        @(negedge clock);
        checkOutput("validEarly", VW'(out_valid), '0);
        checkOutput("busyLoad",   VW'(busy),      VW'(1));
        applyStimulus(dataB[sz*sz-1], 0);
        @(negedge clock);
        checkOutput("validLatency", VW'(out_valid), VW'(1));
        if (expAQ.size() > 0) begin
            eA = expAQ.pop_front();
            eB = expBQ.pop_front();
            eS = expSizeQ.pop_front();
            checkOutput("matA", matrix_a,  eA);
            checkOutput("matB", matrix_b,  eB);
            checkOutput("size", VW'(size), VW'(eS));
            curA    = eA;
            curB    = eB;
            curSize = eS;
        end
    endtask

    task automatic releaseHold();
        @(negedge clock);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clock);
        #1;
        out_ready = 1'b0;
        @(negedge clock);
        checkOutput("relValid", VW'(out_valid), '0);
        checkOutput("relBusy",  VW'(busy),      '0);
        checkOutput("relReady", VW'(in_ready),  VW'(1));
        checkOutput("relKeepA", matrix_a,       curA);
        checkOutput("relKeepB", matrix_b,       curB);
    endtask

    task automatic badHeader(input logic [7:0] h);
        applyStimulus(h, 0);
        @(negedge clock);
        checkOutput("errPulse", VW'(error), VW'(1));
        checkOutput("errBusy",  VW'(busy),  '0);
        @(negedge clock);
        checkOutput("errClear", VW'(error), '0);
        checkOutput("errKeepA", matrix_a,   curA);
        checkOutput("errKeepS", VW'(size),  VW'(curSize));
    endtask

    initial begin
        doReset();

        for (int k = 0; k < 4; k++) begin
            dataA[k] = 8'(k + 1);
            dataB[k] = 8'(k + 5);
        end
        runLoad(2, 0);
        checkOutput("a10", VW'(matrix_a[(1*DIM+0)*WIDTH +: WIDTH]), VW'(3));
        checkOutput("b11", VW'(matrix_b[(1*DIM+1)*WIDTH +: WIDTH]), VW'(8));
        releaseHold();

        badHeader(8'd0);
        badHeader(8'd6);

        for (int k = 0; k < 25; k++) begin
            dataA[k] = 8'($urandom);
            dataB[k] = 8'($urandom);
        end
        runLoad(5, 1);
        checkOutput("a44", VW'(matrix_a[24*WIDTH +: WIDTH]), VW'(dataA[24]));

        // Downstream stalls: new bytes must be refused and the operand set must not move.
        for (int c = 0; c < 10; c++) begin
            @(negedge clock);
            in_valid = 1'b1;
            in_data  = 8'($urandom_range(1, 5));
            #1;
            checkOutput("holdReady", VW'(in_ready),  '0);
            checkOutput("holdValid", VW'(out_valid), VW'(1));
            checkOutput("holdA",     matrix_a,       curA);
            checkOutput("holdB",     matrix_b,       curB);
        end
        releaseHold();

        for (int k = 0; k < 4; k++) begin
            dataA[k] = 8'($urandom_range(1, 255));
            dataB[k] = 8'($urandom_range(1, 255));
        end
        runLoad(2, 0);
        releaseHold();

        applyStimulus(8'd3, 0);
        for (int k = 0; k < 7; k++) applyStimulus(8'(k + 20), 0);
        @(negedge clock);
        checkOutput("midBusy", VW'(busy), VW'(1));
        doReset();
        dataA[0] = 8'd9;
        dataB[0] = 8'd3;
        runLoad(1, 0);
        releaseHold();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
